// File: rtl/pixel_frame_loader.sv
// Serial pixel stream to double-buffered parallel frame bus with a one-cycle commit strobe.
// Optional SOF resynchronisation is enabled by defining PIXEL_SOF_RESYNC_EN.
module pixel_frame_loader #(
  parameter int unsigned PIXELS_NR  = 784,
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned IDX_W      = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_en,
  input  logic [RESOLUTION-1:0]           pixel_in,
  input  logic                            pixel_valid,
  input  logic                            pixel_sof,
  output logic                            pixel_ready,
  output logic [PIXELS_NR*RESOLUTION-1:0] pixels_out,
  output logic                            frame_en,
  output logic [15:0]                     frame_count,
  output logic                            resync_err
);

  localparam int unsigned FRAME_W = PIXELS_NR * RESOLUTION;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS_NR - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [IDX_W-1:0]   index;
  logic [IDX_W-1:0]   wr_idx_c;
  logic [BIT_W-1:0]   wr_bit_c;
  logic [FRAME_W-1:0] shadow;
  logic [FRAME_W-1:0] shadow_nxt;
  logic               accept_c;
  logic               sof_hit_c;
  logic               resync_hit_c;
  logic               commit_c;

  // Ready is a pure state decode so it never waits on pixel_valid.
  assign pixel_ready = (state == FILL);
  assign accept_c    = pixel_ready && pixel_valid;

`ifdef PIXEL_SOF_RESYNC_EN
  assign sof_hit_c    = accept_c && pixel_sof;
  assign resync_hit_c = sof_hit_c && (index != '0);
`else
  logic sof_unused;
  assign sof_unused   = pixel_sof;
  assign sof_hit_c    = 1'b0;
  assign resync_hit_c = 1'b0;
`endif

  // Shadow image including this cycle's pixel, so a commit sees the final pixel.
  always_comb begin
    wr_idx_c   = sof_hit_c ? '0 : index;
    wr_bit_c   = BIT_W'(wr_idx_c) * BIT_W'(RESOLUTION);
    shadow_nxt = shadow;
    if (accept_c) begin
      shadow_nxt[wr_bit_c +: RESOLUTION] = pixel_in;
    end
  end

  always_comb begin
    state_nxt = state;
    commit_c  = 1'b0;
    case (state)
      IDLE: begin
        if (load_en) state_nxt = FILL;
      end
      FILL: begin
        if (accept_c && !sof_hit_c && (index == LAST_IDX)) begin
          state_nxt = COMMIT;
          commit_c  = 1'b1;
        end
      end
      COMMIT: begin
        state_nxt = load_en ? FILL : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Commit is registered on the last-pixel edge so frame_en and pixels_out rise together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index       <= '0;
      shadow      <= '0;
      pixels_out  <= '0;
      frame_en    <= 1'b0;
      frame_count <= '0;
      resync_err  <= 1'b0;
    end else begin
      shadow     <= shadow_nxt;
      frame_en   <= commit_c;
      resync_err <= resync_err | resync_hit_c;
      if (commit_c) begin
        pixels_out  <= shadow_nxt;
        frame_count <= frame_count + 16'd1;
        index       <= '0;
      end else if (accept_c) begin
        index <= sof_hit_c ? IDX_W'(1) : index + IDX_W'(1);
      end
    end
  end

endmodule
